// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-cycle-latency instruction register and saturating fetch counter.
// Optional halt-on-opcode behaviour is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'd10,
  parameter logic [7:0] HALT_OPCODE = 8'b11100000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [7:0]  endereco,
  input  logic [7:0]  instrucao,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [7:0]  branch_target,
  output logic [7:0]  ir_out,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  irpc_q, irpc_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        halt_hit;

`ifdef FETCH_HALT_EN
  // The halt word is presented for one cycle before the state changes.
  assign halt_hit = valid_q && (ir_q == HALT_OPCODE);
  assign halted   = (state_q == HALT);
`else
  assign halt_hit = 1'b0 && (ir_q == HALT_OPCODE);
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      irpc_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irpc_q  <= irpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irpc_d  = irpc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: begin
        if (halt_hit) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (branch_en) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else if (!stall) begin
          ir_d    = instrucao;
          irpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 8'd1;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  assign endereco    = pc_q;
  assign ir_out      = ir_q;
  assign ir_pc       = irpc_q;
  assign ir_valid    = valid_q;
  assign fetch_count = cnt_q;

endmodule
